// File: rtl/return_stack.sv
// Return-address stack for JSB/RET: push stores PC+1, pop presents the top entry
// combinationally so the PC mux can load it in the same cycle.
module return_stack #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_data,
  input  logic                         clear_err,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              we_c;
  logic [PTR_W-1:0]  waddr_c;
  logic [PTR_W-1:0]  top_idx_c;
  logic              empty_c, full_c;

  assign empty_c   = (sp_q == '0);
  assign full_c    = (sp_q == CNT_W'(DEPTH));
  assign top_idx_c = PTR_W'(sp_q - CNT_W'(1));

  // Next-state: resolve the push/pop request against current occupancy
  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q & ~clear_err;
    unf_d   = unf_q & ~clear_err;
    we_c    = 1'b0;
    waddr_c = PTR_W'(sp_q);
    if (!reset) begin
      unique case ({push, pop})
        2'b10: begin
          if (full_c) begin
            ovf_d = 1'b1;
          end else begin
            we_c    = 1'b1;
            waddr_c = PTR_W'(sp_q);
            sp_d    = sp_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (empty_c) begin
            unf_d = 1'b1;
          end else begin
            sp_d = sp_q - CNT_W'(1);
          end
        end
        2'b11: begin
          we_c = 1'b1;
          if (empty_c) begin
            waddr_c = '0;
            sp_d    = CNT_W'(1);
            unf_d   = 1'b1;
          end else begin
            waddr_c = top_idx_c;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is intentionally not reset; validity is tracked by sp_q alone
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_q[waddr_c] <= push_data;
    end
  end

  assign top       = empty_c ? '0 : mem_q[top_idx_c];
  assign count     = sp_q;
  assign empty     = empty_c;
  assign full      = full_c;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed scenarios plus a random
// push/pop stream compared every cycle against a queue-based reference.
module tb_return_stack;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_data;
  logic              clear_err;
  logic [ADDR_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int unsigned tests;
  int unsigned fails;

  int unsigned q[$];
  bit          m_ovf;
  bit          m_unf;

  return_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .clear_err (clear_err),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_top();
    return (q.size() == 0) ? 0 : q[q.size()-1];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(q.size() == DEPTH));
    chk({tag, "_top"},   32'(top),   m_top());
    chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, "_unf"},   32'(underflow), 32'(m_unf));
  endtask

  task automatic model_step(input bit p, input bit o, input int unsigned d, input bit c);
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (p && o) begin
      if (q.size() == 0) begin
        q.push_back(d);
        m_unf = 1'b1;
      end else begin
        q[q.size()-1] = d;
      end
    end else if (p) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(d);
    end else if (o) begin
      if (q.size() == 0) m_unf = 1'b1;
      else void'(q.pop_back());
    end
  endtask

  // Drive one request, check pre-edge outputs (pop data must already be on top), then clock
  task automatic cycle(input bit p, input bit o, input int unsigned d, input bit c, input string tag);
    push      = p;
    pop       = o;
    push_data = ADDR_W'(d);
    clear_err = c;
    #1 check_all(tag);
    @(posedge clk);
    model_step(p, o, d, c);
    @(negedge clk);
    push      = 1'b0;
    pop       = 1'b0;
    clear_err = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    reset = 1'b1;
    push = 1'b0; pop = 1'b0; push_data = '0; clear_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_top",   32'(top),   32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    @(negedge clk);

    // Basic LIFO ordering
    cycle(1, 0, 'h010, 0, "p1"); chk("p1_top_c", 32'(top), 32'h010); chk("p1_cnt_c", 32'(count), 32'd1);
    cycle(1, 0, 'h020, 0, "p2"); chk("p2_top_c", 32'(top), 32'h020); chk("p2_cnt_c", 32'(count), 32'd2);
    cycle(1, 0, 'h030, 0, "p3"); chk("p3_top_c", 32'(top), 32'h030); chk("p3_cnt_c", 32'(count), 32'd3);
    pop = 1'b1; #1 chk("pop_same_cycle_top", 32'(top), 32'h030); pop = 1'b0;
    cycle(0, 1, 0, 0, "pop1");
    cycle(0, 1, 0, 0, "pop2");
    cycle(0, 1, 0, 0, "pop3");
    chk("lifo_empty", 32'(empty), 32'd1);
    chk("lifo_top0",  32'(top),   32'd0);

    // Fill and overflow
    for (int i = 0; i < 9; i++) cycle(1, 0, 'h100 + i, 0, "fill");
    chk("ovf_full",  32'(full),     32'd1);
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_top",   32'(top),      32'h107);
    chk("ovf_count", 32'(count),    32'd8);
    cycle(0, 0, 0, 1, "clr_ovf");
    chk("ovf_cleared", 32'(overflow), 32'd0);
    cycle(1, 1, 'h3FF, 0, "swap_full");
    chk("swap_full_top", 32'(top), 32'h3FF);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, "drain");

    // Underflow stays sticky across valid traffic
    cycle(0, 1, 0, 0, "unf_pop");
    chk("unf_flag",  32'(underflow), 32'd1);
    chk("unf_count", 32'(count),     32'd0);
    chk("unf_top",   32'(top),       32'd0);
    cycle(1, 0, 'h044, 0, "unf_push");
    cycle(0, 1, 0, 0, "unf_pop2");
    chk("unf_sticky", 32'(underflow), 32'd1);
    cycle(0, 1, 0, 1, "unf_set_wins");
    chk("unf_set_wins_flag", 32'(underflow), 32'd1);
    cycle(0, 0, 0, 1, "clr_unf");
    chk("unf_cleared", 32'(underflow), 32'd0);

    // Simultaneous push+pop replaces top; on empty it pushes and flags underflow
    cycle(1, 0, 'h010, 0, "sw_a");
    cycle(1, 0, 'h020, 0, "sw_b");
    cycle(1, 1, 'h0AB, 0, "sw_rep");
    chk("sw_count", 32'(count), 32'd2);
    chk("sw_top",   32'(top),   32'h0AB);
    cycle(0, 1, 0, 0, "sw_d1");
    cycle(0, 1, 0, 0, "sw_d2");
    cycle(1, 1, 'h055, 0, "sw_empty");
    chk("swe_count", 32'(count),     32'd1);
    chk("swe_top",   32'(top),       32'h055);
    chk("swe_unf",   32'(underflow), 32'd1);

    // Asynchronous reset mid-cycle with push held
    for (int i = 0; i < 4; i++) cycle(1, 0, 'h200 + i, 0, "ar_fill");
    chk("ar_pre_count", 32'(count), 32'd5);
    push = 1'b1; push_data = 12'h777;
    #2 reset = 1'b1;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_top",   32'(top),   32'd0);
    chk("ar_flags", 32'({overflow, underflow}), 32'd0);
    @(posedge clk); #1;
    chk("ar_hold_count", 32'(count), 32'd0);
    chk("ar_hold_top",   32'(top),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    push  = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all("ar_post");

    // Random stream: push-biased then pop-biased to reach both boundaries
    for (int n = 0; n < 2000; n++) begin
      int unsigned pp;
      int unsigned r;
      bit p, o, c;
      pp = (n < 1000) ? 60 : 40;
      r  = $urandom_range(0, 99);
      p  = (r < pp);
      o  = ($urandom_range(0, 99) < 100 - pp);
      c  = ($urandom_range(0, 49) == 0);
      cycle(p, o, $urandom_range(0, (1 << ADDR_W) - 1), c, "rnd");
    end
    check_all("rnd_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack that answers the controller's `push`/`pop` requests for subroutine calls and returns. On a JSB cycle (`push`), it stores the return address supplied by the datapath. On a RET cycle (`pop`), it presents the most recent address on `top` so the PC mux (select 2'b11) can load it in the same cycle. It keeps an occupancy count, reports full/empty, and raises sticky error flags on overflow and underflow.

## Interface
- `DEPTH`, 8: number of stack entries; power of two, 2..64.
- `ADDR_W`, 12: width of a stored return address (PC width).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `push`  input  1  store `push_data` this cycle (controller asserts on JSB).
- `pop`  input  1  remove the top entry this cycle (controller asserts on RET).
- `push_data`  input  ADDR_W  return address (PC+1) to store.
- `clear_err`  input  1  synchronous clear of `overflow` and `underflow`.
- `top`  output  ADDR_W  current top entry (combinational from state); 0 when empty.
- `count`  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `empty`  output  1  `count == 0`.
- `full`  output  1  `count == DEPTH`.
- `overflow`  output  1  sticky: a push was attempted while full.
- `underflow`  output  1  sticky: a pop was attempted while empty.

## Operation
- Storage: DEPTH x ADDR_W register array plus pointer `sp`, which is the count of valid entries. `top = mem[sp-1]` when `sp>0`, else 0.
- Entries are not cleared by reset. Only `sp` and the flags are reset. `top` reads 0 whenever the stack is empty.
- Push only, not full: `mem[sp] <= push_data`, then `sp <= sp+1`.
- Push only, full: the push is discarded, and `mem` and `sp` are unchanged. `overflow <= 1`.
- Pop only, not empty: `sp <= sp-1`. The entry data stays in place but becomes invalid.
- Pop only, empty: no state change. `underflow <= 1`. `top` stays 0.
- Push and pop together, not empty: replace the top entry, `mem[sp-1] <= push_data`, with `sp` unchanged and no flag. This holds when full as well.
- Push and pop together, empty: perform the push (`mem[0] <= push_data`, `sp <= 1`) and set `underflow <= 1`.
- `clear_err` clears both flags at the edge. If the same cycle's operation would set a flag, setting wins.
- There is no wrap-around: `sp` saturates at 0 and at DEPTH.

## Timing
- Reset values: `sp=0`, `count=0`, `empty=1`, `full=0`, `top=0`, `overflow=0`, `underflow=0`.
- Reset is asynchronous: assertion clears state without a clock edge. While `reset` is high, `push`/`pop` are ignored.
- Pop latency is 0 cycles for data. `top` is valid combinationally during the RET cycle, so the next PC can be loaded at that same edge. The stack shrinks at that edge.
- Push latency is 1 cycle. The pushed value appears on `top` after the rising edge.
- `count`, `empty` and `full` are derived only from registered `sp`. They never depend combinationally on `push`/`pop`.
- Flags update at the edge following the offending request. They stay set until `clear_err` or `reset`.
- There is no handshake or backpressure. Every request is resolved within its own cycle.

## Test plan
- Reset, then push 0x010, 0x020, 0x030 on consecutive cycles -> `count` reads 1, 2, 3 and `top` reads 0x010, 0x020, 0x030. Then pop three times -> `top` reads 0x030, 0x020, 0x010 during the pop cycles, and finally `empty=1`, `top=0`.
- Push 9 addresses 0x100..0x108 (DEPTH=8) -> `full=1` after 8 pushes. The ninth push sets `overflow`, `top` stays 0x107, `count=8`. Assert `clear_err` -> `overflow=0`.
- Pop on an empty stack -> `underflow=1`, `count=0`, `top=0`. A subsequent valid push/pop keeps `underflow` set until `clear_err`.
- With `top`=0x020 and `count`=2, assert push 0x0AB and pop together -> `count` stays 2 and `top` becomes 0x0AB. With the stack empty, push+pop of 0x055 -> `count=1`, `top=0x055`, `underflow=1`.
- Assert `reset` asynchronously mid-sequence, between edges with `count=5` -> `count=0`, `top=0` and flags 0 immediately. A push held high during reset has no effect.
- Random push/pop stream of 2000 cycles checked against a reference queue model -> `top`, `count` and both flags match every cycle.
